// File: rtl/data_memory_arbiter.sv
// Round-robin, lock-aware arbiter muxing two request ports onto a single-port 64-byte data memory.
// Grant is combinational in the request cycle; responses arrive one cycle later; a waiting port simply holds req.
module data_memory_arbiter #(
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        lock0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic        lock1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic [31:0] mem_address,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [3:0]  MAXB      = 4'(MAX_BURST);

    state_t      state;
    logic        ptr;
    logic [3:0]  burst;
    logic        own0, own1;
    logic        sel_we;
    logic        legal;

    always_comb begin
        own0 = (state == OWN0) && req0 && (burst < MAXB);
        own1 = (state == OWN1) && req1 && (burst < MAXB);
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (own0) begin
            gnt0 = 1'b1;
        end else if (own1) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            gnt0 = ~ptr;
            gnt1 = ptr;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_comb begin
        mem_address = '0;
        WriteData   = '0;
        sel_we      = 1'b0;
        if (gnt1) begin
            mem_address = addr1;
            WriteData   = wdata1;
            sel_we      = we1;
        end else if (gnt0) begin
            mem_address = addr0;
            WriteData   = wdata0;
            sel_we      = we0;
        end
        // Unsigned compare: top-of-space addresses are out of range, never wrapped.
        legal    = (mem_address[1:0] == 2'b00) && (mem_address <= LAST_WORD);
        MemWrite = (gnt0 | gnt1) & sel_we & legal;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            burst   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (gnt0) begin
                err0   <= ~legal;
                rdata0 <= (!we0 && legal) ? ReadData : '0;
            end
            if (gnt1) begin
                err1   <= ~legal;
                rdata1 <= (!we1 && legal) ? ReadData : '0;
            end

            // A grant won by arbitration rather than ownership starts a fresh burst.
            if (gnt0) begin
                ptr <= 1'b1;
                if (lock0) begin
                    state <= OWN0;
                    burst <= own0 ? burst + 4'd1 : 4'd1;
                end else begin
                    state <= IDLE;
                    burst <= '0;
                end
            end else if (gnt1) begin
                ptr <= 1'b0;
                if (lock1) begin
                    state <= OWN1;
                    burst <= own1 ? burst + 4'd1 : 4'd1;
                end else begin
                    state <= IDLE;
                    burst <= '0;
                end
            end else begin
                state <= IDLE;
                burst <= '0;
            end
        end
    end

endmodule
